// File: rtl/regexmem_skid_if.sv
// EX/MEM boundary bundle: EX-side payload and handshake plus MEM-side registered outputs.
// The master drives the EX inputs and MEM ready; the slave is the pipeline register.
interface regexmem_skid_if #(
    parameter int PC_W         = 9,
    parameter int RF_ADDRESS_W = 5,
    parameter int DATA_W       = 32
);
    logic                    flush;
    logic                    valid_in;
    logic                    ready_out;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic [2:0]              MemRead;
    logic [1:0]              MemWrite;
    logic                    Branch_Taken;
    logic [DATA_W-1:0]       ALUResult;
    logic [DATA_W-1:0]       Reg2;
    logic [RF_ADDRESS_W-1:0] RD;
    logic [PC_W-1:0]         PCPlus4;
    logic [6:0]              opcode;

    logic                    valid_out;
    logic                    ready_in;
    logic                    MemtoReg_Out;
    logic                    RegWrite_Out;
    logic [2:0]              MemRead_Out;
    logic [1:0]              MemWrite_Out;
    logic                    Branch_Taken_Out;
    logic [DATA_W-1:0]       ALUResult_Out;
    logic [DATA_W-1:0]       Reg2_Out;
    logic [RF_ADDRESS_W-1:0] RD_Out;
    logic [PC_W-1:0]         PCPlus4_Out;
    logic [6:0]              opcode_Out;

    modport master (
        output flush, valid_in, MemtoReg, RegWrite, MemRead, MemWrite, Branch_Taken,
               ALUResult, Reg2, RD, PCPlus4, opcode, ready_in,
        input  ready_out, valid_out, MemtoReg_Out, RegWrite_Out, MemRead_Out, MemWrite_Out,
               Branch_Taken_Out, ALUResult_Out, Reg2_Out, RD_Out, PCPlus4_Out, opcode_Out
    );

    modport slave (
        input  flush, valid_in, MemtoReg, RegWrite, MemRead, MemWrite, Branch_Taken,
               ALUResult, Reg2, RD, PCPlus4, opcode, ready_in,
        output ready_out, valid_out, MemtoReg_Out, RegWrite_Out, MemRead_Out, MemWrite_Out,
               Branch_Taken_Out, ALUResult_Out, Reg2_Out, RD_Out, PCPlus4_Out, opcode_Out
    );
endinterface

// File: rtl/regexmem_skid.sv
// EX/MEM pipeline register with a 2-entry skid buffer: ready_out depends only on
// state, so MEM backpressure never has a combinational path back into EX.
module regexmem_skid #(
    parameter int PC_W         = 9,
    parameter int RF_ADDRESS_W = 5,
    parameter int DATA_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    regexmem_skid_if.slave  bus
);
    localparam int CTRL_W = 8;
    localparam int PAY_W  = CTRL_W + 2 * DATA_W + RF_ADDRESS_W + PC_W + 7;
    localparam int ALU_LO = CTRL_W;
    localparam int R2_LO  = ALU_LO + DATA_W;
    localparam int RD_LO  = R2_LO + DATA_W;
    localparam int PC_LO  = RD_LO + RF_ADDRESS_W;
    localparam int OP_LO  = PC_LO + PC_W;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t              r_state_reg;
    state_t              w_state_next;
    logic [PAY_W-1:0]    r_main_reg;
    logic [PAY_W-1:0]    r_skid_reg;
    logic [PAY_W-1:0]    w_payload_in;
    logic [CTRL_W-1:0]   w_ctrl_gated;
    logic                w_ready;
    logic                w_valid;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_main_from_in;
    logic                w_main_from_skid;
    logic                w_skid_from_in;

    // Control bits occupy the low byte so bubble gating is a simple per-bit AND.
    assign w_payload_in = {bus.opcode, bus.PCPlus4, bus.RD, bus.Reg2, bus.ALUResult,
                           bus.Branch_Taken, bus.MemWrite, bus.MemRead,
                           bus.RegWrite, bus.MemtoReg};

    assign w_ready    = (r_state_reg != ST_SKID) & ~reset;
    assign w_valid    = (r_state_reg != ST_EMPTY);
    assign w_in_xfer  = bus.valid_in & w_ready;
    assign w_out_xfer = w_valid & bus.ready_in;

    always_comb begin
        w_state_next     = r_state_reg;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (bus.flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state_reg)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_next   = ST_FULL;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b10: begin
                            w_state_next   = ST_SKID;
                            w_skid_from_in = 1'b1;
                        end
                        2'b01: w_state_next = ST_EMPTY;
                        2'b11: w_main_from_in = 1'b1;
                        default: w_state_next = ST_FULL;
                    endcase
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_next     = ST_FULL;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg <= ST_EMPTY;
            r_main_reg  <= '0;
            r_skid_reg  <= '0;
        end else begin
            r_state_reg <= w_state_next;
            if (w_main_from_in) begin
                r_main_reg <= w_payload_in;
            end else if (w_main_from_skid) begin
                r_main_reg <= r_skid_reg;
            end
            if (w_skid_from_in) begin
                r_skid_reg <= w_payload_in;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign w_ctrl_gated[gi] = r_main_reg[gi] & w_valid;
        end
    endgenerate

    assign bus.ready_out        = w_ready;
    assign bus.valid_out        = w_valid;
    assign bus.MemtoReg_Out     = w_ctrl_gated[0];
    assign bus.RegWrite_Out     = w_ctrl_gated[1];
    assign bus.MemRead_Out      = w_ctrl_gated[4:2];
    assign bus.MemWrite_Out     = w_ctrl_gated[6:5];
    assign bus.Branch_Taken_Out = w_ctrl_gated[7];
    assign bus.ALUResult_Out    = r_main_reg[ALU_LO +: DATA_W];
    assign bus.Reg2_Out         = r_main_reg[R2_LO +: DATA_W];
    assign bus.RD_Out           = r_main_reg[RD_LO +: RF_ADDRESS_W];
    assign bus.PCPlus4_Out      = r_main_reg[PC_LO +: PC_W];
    assign bus.opcode_Out       = r_main_reg[OP_LO +: 7];
endmodule
